// File: rtl/serial_image_transmitter_pkg.sv
// Shared link constants and transmitter state encoding
// for the host-to-NN serial pixel link.
package nn_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        LOW,
        HIGH,
        DONE
    } tx_state_t;

    localparam int NUM_PIXELS     = 784;
    localparam int PIXEL_WIDTH    = 16;
    localparam int SERIAL_CLK_DIV = 25;

endpackage

// File: rtl/serial_image_transmitter_if.sv
// Control, pixel RAM and serial link signals of the
// image transmitter.
interface serial_image_transmitter_if #(
    parameter int dataWidth = 16,
    parameter int addrWidth = 10
) ();

    logic                 start;
    logic                 abort;
    logic [addrWidth-1:0] memAddr;
    logic [dataWidth-1:0] memRdData;
    logic                 serialClock;
    logic                 serialData;
    logic                 busy;
    logic                 done;

    modport master (
        input  start,
        input  abort,
        input  memRdData,
        output memAddr,
        output serialClock,
        output serialData,
        output busy,
        output done
    );

    modport slave (
        output start,
        output abort,
        output memRdData,
        input  memAddr,
        input  serialClock,
        input  serialData,
        input  busy,
        input  done
    );

endinterface

// File: rtl/serial_image_transmitter_bit_timer.sv
// Half-period timer for the serial link clock:
// phaseEnd marks the last clk cycle of each half-period.
module serial_bit_timer #(
    parameter int clkDiv = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic phaseEnd
);

    localparam int CW = $clog2(clkDiv + 1);
    localparam logic [CW-1:0] LAST = CW'(clkDiv - 1);

    logic [CW-1:0] r_divCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_divCnt <= '0;
        end else if (clear || phaseEnd) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    assign phaseEnd = (r_divCnt == LAST);

endmodule

// File: rtl/serial_image_transmitter.sv
// Reads a pixel frame from synchronous RAM and sends it
// MSB first over the serialClock/serialData link.
module serial_image_transmitter
    import nn_serial_pkg::*;
#(
    parameter int numInputs = NUM_PIXELS,
    parameter int dataWidth = PIXEL_WIDTH,
    parameter int clkDiv    = SERIAL_CLK_DIV,
    parameter int addrWidth = $clog2(numInputs)
) (
    input logic clk,
    input logic reset,
    serial_image_transmitter_if.master bus
);

    localparam int BW = (dataWidth > 1) ? $clog2(dataWidth) : 1;

    tx_state_t            r_state;
    tx_state_t            w_next;
    logic [addrWidth-1:0] r_memAddr;
    logic [dataWidth-1:0] r_shift;
    logic [BW-1:0]        r_bitCnt;
    logic                 r_sclk;
    logic                 r_sdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_phaseEnd;
    logic                 w_clear;
    logic                 w_lastBit;
    logic                 w_lastPix;
    logic                 w_abort;

    assign w_abort   = bus.abort && (r_state != IDLE);
    assign w_lastBit = (r_bitCnt == BW'(dataWidth - 1));
    assign w_lastPix = (r_memAddr == addrWidth'(numInputs - 1));
    assign w_clear   = !((r_state == LOW) || (r_state == HIGH));

    serial_bit_timer #(
        .clkDiv(clkDiv)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .phaseEnd(w_phaseEnd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:  if (bus.start) w_next = FETCH;
                FETCH: w_next = LOAD;
                LOAD:  w_next = LOW;
                LOW:   if (w_phaseEnd) w_next = HIGH;
                HIGH: begin
                    if (w_phaseEnd) begin
                        if (!w_lastBit) w_next = LOW;
                        else if (!w_lastPix) w_next = FETCH;
                        else w_next = DONE;
                    end
                end
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // The shifter keeps the not-yet-sent bits left-aligned,
    // so the next bit to drive is always its MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memAddr <= '0;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_memAddr <= '0;
                r_sclk    <= 1'b0;
                r_sdata   <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_memAddr <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    FETCH: r_sclk <= 1'b0;
                    LOAD: begin
                        r_shift  <= {bus.memRdData[dataWidth-2:0], 1'b0};
                        r_sdata  <= bus.memRdData[dataWidth-1];
                        r_bitCnt <= '0;
                    end
                    LOW: if (w_phaseEnd) r_sclk <= 1'b1;
                    HIGH: begin
                        if (w_phaseEnd) begin
                            r_sclk <= 1'b0;
                            if (!w_lastBit) begin
                                r_sdata  <= r_shift[dataWidth-1];
                                r_shift  <= r_shift << 1;
                                r_bitCnt <= r_bitCnt + 1'b1;
                            end else if (!w_lastPix) begin
                                r_memAddr <= r_memAddr + 1'b1;
                            end else begin
                                r_sdata <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_memAddr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.memAddr     = r_memAddr;
    assign bus.serialClock = r_sclk;
    assign bus.serialData  = r_sdata;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
